// File: rtl/vga_rx_decoder.sv
// VGA receive-side decoder: registers the sync/RGB pins, measures line and frame
// timing against the nominal mode, locks after clean frames and emits an x/y pixel stream.
module vga_rx_decoder #(
  parameter int unsigned H_SYNC_TIME  = 136,
  parameter int unsigned H_BACK_PORCH = 160,
  parameter int unsigned H_ADDR_TIME  = 1024,
  parameter int unsigned H_TOTAL_TIME = 1344,
  parameter int unsigned H_CNT_WIDTH  = 11,
  parameter int unsigned V_SYNC_TIME  = 6,
  parameter int unsigned V_BACK_PORCH = 29,
  parameter int unsigned V_ADDR_TIME  = 768,
  parameter int unsigned V_TOTAL_TIME = 806,
  parameter int unsigned V_CNT_WIDTH  = 10,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   h_sync,
  input  logic                   v_sync,
  input  logic [4:0]             red,
  input  logic [5:0]             green,
  input  logic [4:0]             blue,
  output logic                   pix_valid,
  output logic [15:0]            pix_data,
  output logic [H_CNT_WIDTH-1:0] pix_x,
  output logic [V_CNT_WIDTH-1:0] pix_y,
  output logic                   frame_start,
  output logic                   locked,
  output logic                   timing_err
);

  localparam int unsigned H_ACT_START = H_SYNC_TIME + H_BACK_PORCH;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ADDR_TIME;
  localparam int unsigned V_ACT_START = V_SYNC_TIME + V_BACK_PORCH;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ADDR_TIME;
  localparam int unsigned GW          = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [H_CNT_WIDTH-1:0] H_MAX = '1;
  localparam logic [V_CNT_WIDTH-1:0] V_MAX = '1;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t                 state, state_next;
  logic [GW-1:0]          good_cnt, good_next;
  logic                   h_s1, h_s2, v_s1, v_prev;
  logic [15:0]            rgb_s1;
  logic [H_CNT_WIDTH-1:0] h_cnt_q, h_cnt, h_off;
  logic [V_CNT_WIDTH-1:0] v_cnt_q, v_cnt, v_inc, v_off;
  logic                   h_fall, h_rise, v_fall, v_rise;
  logic                   h_armed, v_armed;
  logic                   err, act;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      h_s1   <= 1'b1;
      h_s2   <= 1'b1;
      v_s1   <= 1'b1;
      rgb_s1 <= '0;
    end else begin
      h_s1   <= h_sync;
      h_s2   <= h_s1;
      v_s1   <= v_sync;
      rgb_s1 <= {red, green, blue};
    end
  end

  // h_cnt/v_cnt are the counts belonging to the s1 sample; the _q copies hold the previous one,
  // so length checks at a fall see the last count of the line/frame that just ended.
  always_comb begin
    h_fall = h_s2 & ~h_s1;
    h_rise = ~h_s2 & h_s1;
    v_fall = h_fall & ~v_s1 & v_prev;
    v_rise = h_fall & v_s1 & ~v_prev;
    h_cnt  = h_fall ? '0 : ((h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + H_CNT_WIDTH'(1));
    v_inc  = (v_cnt_q == V_MAX) ? V_MAX : v_cnt_q + V_CNT_WIDTH'(1);
    v_cnt  = !h_fall ? v_cnt_q : (v_fall ? '0 : v_inc);
    err    = (h_fall & h_armed & (h_cnt_q != H_CNT_WIDTH'(H_TOTAL_TIME - 1)))
           | (h_rise & (h_cnt != H_CNT_WIDTH'(H_SYNC_TIME)))
           | (v_fall & v_armed & (v_cnt_q != V_CNT_WIDTH'(V_TOTAL_TIME - 1)))
           | (v_rise & (v_cnt != V_CNT_WIDTH'(V_SYNC_TIME)))
           | (~h_fall & (h_cnt == H_MAX));
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      v_prev  <= 1'b1;
      h_armed <= 1'b0;
      v_armed <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt;
      v_cnt_q <= v_cnt;
      if (h_fall) v_prev <= v_s1;
      if (state == SEARCH) begin
        h_armed <= 1'b0;
        v_armed <= 1'b0;
      end else begin
        if (h_fall) h_armed <= 1'b1;
        if (v_fall) v_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    case (state)
      SEARCH: begin
        if (v_fall) begin
          state_next = MEASURE;
          good_next  = '0;
        end
      end
      MEASURE: begin
        if (err) begin
          state_next = SEARCH;
        end else if (v_fall) begin
          good_next = good_cnt + GW'(1);
          if (good_cnt == GW'(LOCK_FRAMES - 1)) state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (err) state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
  end

  // Gating on the next state drops pix_valid on the same clock that locked falls.
  always_comb begin
    h_off = h_cnt - H_CNT_WIDTH'(H_ACT_START);
    v_off = v_cnt - V_CNT_WIDTH'(V_ACT_START);
    act   = (32'(h_cnt) >= H_ACT_START) && (32'(h_cnt) < H_ACT_END)
         && (32'(v_cnt) >= V_ACT_START) && (32'(v_cnt) < V_ACT_END)
         && (state_next == LOCKED);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      pix_valid   <= act;
      pix_data    <= act ? rgb_s1 : '0;
      pix_x       <= act ? h_off : '0;
      pix_y       <= act ? v_off : '0;
      frame_start <= act && (h_off == '0) && (v_off == '0);
      timing_err  <= err && (state != SEARCH);
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder on a reduced video mode: a transmitter drives lines/frames,
// every driven clock queues the expected output two clocks later, a monitor compares.
module tb_vga_rx_decoder;
  localparam int HS = 3, HBP = 2, HA = 8, HT = 16, HW = 5;
  localparam int VS = 2, VBP = 1, VA = 4, VT = 8, VW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          h_sync = 1'b1, v_sync = 1'b1;
  logic [4:0]    red = '0;
  logic [5:0]    green = '0;
  logic [4:0]    blue = '0;
  logic          pix_valid, frame_start, locked, timing_err;
  logic [15:0]   pix_data;
  logic [HW-1:0] pix_x;
  logic [VW-1:0] pix_y;

  typedef struct {
    longint      cyc;
    logic [28:0] exp;
  } rec_t;

  rec_t   q[$];
  longint cyc = 0;
  int     total = 0, bad = 0, pv_total = 0, fs_total = 0;
  bit     exp_lk = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_rx_decoder #(
    .H_SYNC_TIME(HS), .H_BACK_PORCH(HBP), .H_ADDR_TIME(HA), .H_TOTAL_TIME(HT), .H_CNT_WIDTH(HW),
    .V_SYNC_TIME(VS), .V_BACK_PORCH(VBP), .V_ADDR_TIME(VA), .V_TOTAL_TIME(VT), .V_CNT_WIDTH(VW),
    .LOCK_FRAMES(2)
  ) dut (
    .sys_clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync),
    .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err)
  );

  function automatic logic [28:0] outs();
    return {pix_valid, pix_data, pix_x, pix_y, frame_start, locked, timing_err};
  endfunction

  task automatic chk(input string tag, input logic [28:0] obs, input logic [28:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (valid,data,x,y,fs,locked,err)", tag, obs, expv);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (pix_valid === 1'b1) pv_total++;
      if (frame_start === 1'b1) fs_total++;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        chk($sformatf("stream@%0d", cyc), outs(), q[0].exp);
        void'(q.pop_front());
      end
    end
  endtask

  task automatic drive(input logic h, input logic v, input logic [15:0] pin, input logic [28:0] e);
    rec_t r;
    @(posedge clk);
    #1;
    h_sync = h;
    v_sync = v;
    {red, green, blue} = pin;
    r.cyc = cyc + 2;
    r.exp = e;
    if (!rst) q.push_back(r);
  endtask

  // err_at: index within the line of the sample whose timing fault must raise timing_err
  task automatic send_line(input int vline, input int len, input int sw, input int err_at);
    int          x, y;
    logic        inwin, act;
    logic [15:0] val, pin;
    logic [28:0] e;
    for (int j = 0; j < len; j++) begin
      if (j == err_at) exp_lk = 1'b0;
      x     = j - (HS + HBP);
      y     = vline - (VS + VBP);
      inwin = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
      act   = inwin && exp_lk;
      val   = 16'(x ^ (y << 6));
      pin   = inwin ? val : 16'($urandom);
      e = {act, act ? val : 16'h0, act ? HW'(x) : '0, act ? VW'(y) : '0,
           act && (x == 0) && (y == 0), exp_lk, (j == err_at)};
      drive((j < sw) ? 1'b0 : 1'b1, (vline < VS) ? 1'b0 : 1'b1, pin, e);
    end
  endtask

  task automatic send_frame();
    for (int v = 0; v < VT; v++) send_line(v, HT, HS, -1);
  endtask

  task automatic relock(input string tag);
    int p0, f0;
    exp_lk = 1'b0;
    send_frame();
    send_frame();
    exp_lk = 1'b1;
    p0 = pv_total;
    f0 = fs_total;
    send_frame();
    chk({tag, "_pix_count"}, 29'(pv_total - p0), 29'(HA * VA));
    chk({tag, "_fs_count"}, 29'(fs_total - f0), 29'd1);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", outs(), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    relock("initial_lock");

    // line 4 one clock short: error seen at the next line start
    for (int v = 0; v < 4; v++) send_line(v, HT, HS, -1);
    send_line(4, HT - 1, HS, -1);
    send_line(5, HT, HS, 0);
    send_line(6, HT, HS, -1);
    send_line(7, HT, HS, -1);
    relock("short_line");

    // h_sync low one clock too few
    for (int v = 0; v < 4; v++) send_line(v, HT, HS, -1);
    send_line(4, HT, HS - 1, HS - 1);
    for (int v = 5; v < VT; v++) send_line(v, HT, HS, -1);
    relock("narrow_sync");

    // h_sync missing long enough to saturate the line counter
    for (int v = 0; v < 4; v++) send_line(v, HT, HS, -1);
    send_line(4, 40, HS, (1 << HW) - 1);
    for (int v = 5; v < VT; v++) send_line(v, HT, HS, -1);
    relock("saturation");

    // asynchronous reset in the middle of a locked frame
    for (int v = 0; v < 5; v++) send_line(v, HT, HS, -1);
    @(posedge clk);
    #1;
    chk("pre_reset_locked", 29'(locked), 29'd1);
    rst = 1'b1;
    q.delete();
    #1;
    chk("reset_async", outs(), '0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", outs(), '0);
    rst = 1'b0;
    exp_lk = 1'b0;
    for (int v = 5; v < VT; v++) send_line(v, HT, HS, -1);
    relock("after_reset");

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 29'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
